minterm_table_sweeper: RTL and testbench

//  Programmable N-input single-output truth table: output = OR of the minterms set in a 2^N-bit mask
//  (bit k set => minterm m(k) present). Two paths: a registered point-evaluation port, and a

---
 rtl/minterm_table_sweeper_pkg.sv | 20 ++
 rtl/minterm_table_sweeper_if.sv | 14 +
 rtl/minterm_mux.sv | 14 +
 rtl/minterm_table_sweeper.sv | 129 ++++++++++++
 tb/tb_minterm_table_sweeper.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/minterm_table_sweeper_pkg.sv
// Shared types and constants for the minterm truth-table sweeper.
// Latency: none (declarations only).
// Backpressure: not applicable.
package minterm_table_sweeper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Default mask: minterms m(2,3,6,7) of a 3-input function.
  localparam logic [7:0] MASK_RST_DEFAULT = 8'hCC;

  // Number of rows in the truth table of an n-input function.
  function automatic int table_depth(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/minterm_table_sweeper_if.sv
// Valid/ready sample stream carrying (minterm index, table value).
// Latency: none (wires only).
// Backpressure: source holds idx/val stable while valid is high and ready is low.
interface minterm_table_sweeper_if #(
  parameter int N = 3
);
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_idx;
  logic         out_val;

  modport master (output out_valid, output out_idx, output out_val, input out_ready);
  modport slave  (input out_valid, input out_idx, input out_val, output out_ready);
endinterface

// File: rtl/minterm_mux.sv
// Selects one bit of the minterm mask: out = mask[sel].
// Latency: combinational.
// Backpressure: none.
module minterm_mux #(
  parameter int N = 3
) (
  input  logic [(1<<N)-1:0] mask,
  input  logic [N-1:0]      sel,
  output logic              bit_out
);

  assign bit_out = mask[sel];

endmodule

// File: rtl/minterm_table_sweeper.sv
// Programmable N-input truth table with a registered point-eval port and a full-table sweep stream.
// Latency: eval_out 1 cycle; sweep = start cycle + DEPTH transfers + 1 DONE cycle.
// Backpressure: sweep stalls with idx/val held while out_ready is low; start and load ignored while busy.
module minterm_table_sweeper
  import minterm_table_sweeper_pkg::*;
#(
  parameter int                N        = 3,
  parameter logic [(1<<N)-1:0] MASK_RST = MASK_RST_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [(1<<N)-1:0]     load_mask,
  input  logic [N-1:0]          eval_in,
  output logic                  eval_out,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [N:0]            ones_cnt,
  minterm_table_sweeper_if.master stream
);

  localparam int             DEPTH    = table_depth(N);
  localparam logic [N-1:0]   IDX_LAST = {N{1'b1}};

  logic [DEPTH-1:0] mask;
  state_t           state_q, state_d;
  logic [N-1:0]     idx_q, idx_d;
  logic             valid_q, valid_d;
  logic [N:0]       acc_q, acc_d;
  logic [N:0]       ones_d;
  logic             eval_bit;
  logic             sweep_bit;
  logic             xfer;

  minterm_mux #(.N(N)) u_eval_mux (
    .mask    (mask),
    .sel     (eval_in),
    .bit_out (eval_bit)
  );

  minterm_mux #(.N(N)) u_sweep_mux (
    .mask    (mask),
    .sel     (idx_q),
    .bit_out (sweep_bit)
  );

  assign xfer             = valid_q & stream.out_ready;
  assign busy             = (state_q != ST_IDLE);
  assign done             = (state_q == ST_DONE);
  assign stream.out_valid = valid_q;
  assign stream.out_idx   = idx_q;
  // Gated so out_val reads 0 whenever no sample is offered.
  assign stream.out_val   = valid_q & sweep_bit;

  // Mask register: writable only in IDLE so a sweep always sees one consistent table.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask <= MASK_RST;
    end else if (load && (state_q == ST_IDLE)) begin
      mask <= load_mask;
    end
  end

  // Point evaluation against the pre-edge mask, independent of the sweep FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eval_out <= 1'b0;
    end else begin
      eval_out <= eval_bit;
    end
  end

  // Sweep FSM state, index counter, accumulator and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      acc_q    <= '0;
      ones_cnt <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
      acc_q    <= acc_d;
      ones_cnt <= ones_d;
    end
  end

  // Next-state logic: launch on start, step on each transfer, publish the count in DONE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    acc_d   = acc_q;
    ones_d  = ones_cnt;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SWEEP;
          idx_d   = '0;
          acc_d   = '0;
          valid_d = 1'b1;
        end
      end
      ST_SWEEP: begin
        if (xfer) begin
          acc_d = acc_q + {{N{1'b0}}, sweep_bit};
          if (idx_q == IDX_LAST) begin
            state_d = ST_DONE;
            valid_d = 1'b0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        ones_d  = acc_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_minterm_table_sweeper.sv
// Directed bench for minterm_table_sweeper (N=3).
// Latency: checks eval_out one cycle after eval_in, sweep samples per transfer.
// Backpressure: exercises out_ready stalls and ignored start/load while busy.
module tb_minterm_table_sweeper;

  logic       clk;
  logic       rst_n;
  logic       load;
  logic [7:0] load_mask;
  logic [2:0] eval_in;
  logic       eval_out;
  logic       start;
  logic       busy;
  logic       done;
  logic [3:0] ones_cnt;

  int vectors = 0;
  int errors  = 0;
  logic [3:0] last_ones = 4'd0;

  minterm_table_sweeper_if #(.N(3)) s_if ();

  minterm_table_sweeper #(.N(3), .MASK_RST(8'hCC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_mask (load_mask),
    .eval_in   (eval_in),
    .eval_out  (eval_out),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .ones_cnt  (ones_cnt),
    .stream    (s_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load = 1'b0; load_mask = 8'h00; eval_in = 3'd2; start = 1'b0;
    s_if.out_ready = 1'b1;
    #23;
    vectors++;
    if ({eval_out, s_if.out_valid, s_if.out_idx, s_if.out_val, busy, done, ones_cnt} !== 11'b0) begin
      errors++;
      $display("FAIL reset_outputs: got eval=%b vld=%b idx=%0d val=%b busy=%b done=%b ones=%0d, want all 0",
               eval_out, s_if.out_valid, s_if.out_idx, s_if.out_val, busy, done, ones_cnt);
    end
    #4 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_eval();
    logic exp_tab [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 8; k++) begin
      eval_in = 3'(k);
      tick();
      vectors++;
      if (eval_out !== exp_tab[k]) begin
        errors++;
        $display("FAIL eval_%0d: got %b want %b", k, eval_out, exp_tab[k]);
      end
    end
  endtask

  // Load and eval in the same cycle: old mask first, new mask next cycle.
  task automatic test_eval_load();
    eval_in = 3'd0; load = 1'b1; load_mask = 8'h01;
    tick();
    load = 1'b0;
    vectors++;
    if (eval_out !== 1'b0) begin
      errors++;
      $display("FAIL eval_load_old: got %b want 0", eval_out);
    end
    tick();
    vectors++;
    if (eval_out !== 1'b1) begin
      errors++;
      $display("FAIL eval_load_new: got %b want 1", eval_out);
    end
  endtask

  task automatic test_sweep(input string name, input logic [7:0] m, input bit do_load,
                            input bit same_cycle, input bit toggle, input int inject_at,
                            input logic [3:0] exp_ones);
    int count = 0;
    int dones = 0;
    int cyc;
    if (do_load && !same_cycle) begin
      load = 1'b1; load_mask = m;
      tick();
      load = 1'b0;
    end
    start = 1'b1;
    if (same_cycle) begin
      load = 1'b1; load_mask = m;
    end
    tick();
    start = 1'b0; load = 1'b0;
    vectors++;
    if (busy !== 1'b1 || s_if.out_valid !== 1'b1 || ones_cnt !== last_ones) begin
      errors++;
      $display("FAIL %s_launch: got busy=%b vld=%b ones=%0d want busy=1 vld=1 ones=%0d",
               name, busy, s_if.out_valid, ones_cnt, last_ones);
    end
    for (cyc = 0; cyc < 64; cyc++) begin
      load = 1'b0; start = 1'b0;
      if (cyc == inject_at) begin
        load = 1'b1; load_mask = 8'h01; start = 1'b1;
      end
      s_if.out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      if (done === 1'b1) dones++;
      if (s_if.out_valid === 1'b1) begin
        vectors++;
        if (count >= 8) begin
          errors++;
          $display("FAIL %s_extra_sample: got sample %0d idx=%0d want none past 7", name, count, s_if.out_idx);
        end else if (s_if.out_idx !== 3'(count) || s_if.out_val !== m[count]) begin
          errors++;
          $display("FAIL %s_sample_%0d: got idx=%0d val=%b want idx=%0d val=%b",
                   name, count, s_if.out_idx, s_if.out_val, count, m[count]);
        end
        if (s_if.out_ready) count++;
      end
      if (count >= 8 && busy === 1'b0) break;
      tick();
    end
    load = 1'b0; start = 1'b0; s_if.out_ready = 1'b0;
    if (cyc >= 64) begin
      errors++;
      $display("FAIL %s_timeout: got %0d samples busy=%b want sweep finished", name, count, busy);
    end
    repeat (2) begin
      tick();
      if (done === 1'b1) dones++;
    end
    vectors++;
    if (count != 8 || dones != 1) begin
      errors++;
      $display("FAIL %s_framing: got samples=%0d done_pulses=%0d want 8 and 1", name, count, dones);
    end
    vectors++;
    if (ones_cnt !== exp_ones) begin
      errors++;
      $display("FAIL %s_ones: got %0d want %0d", name, ones_cnt, exp_ones);
    end
    last_ones = exp_ones;
  endtask

  // start and load during a sweep are ignored; mask stays 8'hCC afterwards.
  task automatic test_ignore_busy();
    test_sweep("busy_ignore", 8'hCC, 1'b1, 1'b0, 1'b0, 3, 4'd4);
    eval_in = 3'd2;
    tick();
    vectors++;
    if (eval_out !== 1'b1) begin
      errors++;
      $display("FAIL busy_ignore_mask: got eval[2]=%b want 1", eval_out);
    end
    vectors++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_ignore_idle: got busy=%b want 0", busy);
    end
  endtask

  // Reset after idx 5 is accepted aborts the sweep and restores the reset mask.
  task automatic test_reset_mid_sweep();
    load = 1'b1; load_mask = 8'hFF;
    tick();
    load = 1'b0; s_if.out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    vectors++;
    if (s_if.out_idx !== 3'd6 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_progress: got idx=%0d busy=%b want idx=6 busy=1", s_if.out_idx, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({eval_out, s_if.out_valid, s_if.out_idx, s_if.out_val, busy, done, ones_cnt} !== 11'b0) begin
      errors++;
      $display("FAIL midrst_outputs: got eval=%b vld=%b idx=%0d val=%b busy=%b done=%b ones=%0d, want all 0",
               eval_out, s_if.out_valid, s_if.out_idx, s_if.out_val, busy, done, ones_cnt);
    end
    s_if.out_ready = 1'b0;
    #3 rst_n = 1'b1;
    tick();
    last_ones = 4'd0;
    test_sweep("post_reset", 8'hCC, 1'b0, 1'b0, 1'b0, -1, 4'd4);
  endtask

  initial begin
    test_reset();
    test_eval();
    test_eval_load();
    test_sweep("basic_cc", 8'hCC, 1'b1, 1'b0, 1'b0, -1, 4'd4);
    test_sweep("xor3_stall", 8'h96, 1'b1, 1'b0, 1'b1, -1, 4'd4);
    test_sweep("all_ones", 8'hFF, 1'b1, 1'b0, 1'b0, -1, 4'd8);
    test_sweep("all_zero", 8'h00, 1'b1, 1'b0, 1'b0, -1, 4'd0);
    test_sweep("load_start", 8'h0F, 1'b1, 1'b1, 1'b0, -1, 4'd4);
    test_ignore_busy();
    test_reset_mid_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
